// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline front end and the stall/flush sequencer.
// The master side reports hazards; the slave side (the sequencer) returns the controls.
interface pipe_stall_ctrl_if;
    // Hazard sources from the pipeline
    logic        ExMemRead;
    logic [4:0]  ExRt;
    logic [4:0]  IdRs;
    logic [4:0]  IdRt;
    logic        IdUsesRt;
    logic        BranchTaken;
    logic        IdMulDiv;
    logic        IdUsesMd;
    logic        ImemReady;

    // Controls returned to the pipeline
    logic        PcWrite;
    logic        IfIdWrite;
    logic        IfFlush;
    logic        IdExBubble;
    logic        MdStart;
    logic        MdBusy;
    logic [31:0] StallCount;

    modport master (
        output ExMemRead, ExRt, IdRs, IdRt, IdUsesRt, BranchTaken, IdMulDiv, IdUsesMd,
               ImemReady,
        input  PcWrite, IfIdWrite, IfFlush, IdExBubble, MdStart, MdBusy, StallCount
    );

    modport slave (
        input  ExMemRead, ExRt, IdRs, IdRt, IdUsesRt, BranchTaken, IdMulDiv, IdUsesMd,
               ImemReady,
        output PcWrite, IfIdWrite, IfFlush, IdExBubble, MdStart, MdBusy, StallCount
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage front end: load-use, mul/div occupancy,
// branch redirect and imem wait, resolved in a single priority decision.
module pipe_stall_ctrl #(
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stall_ctrl_if.slave   bus
);

    typedef enum logic {
        StRun,
        StMdBusy
    } state_e;

    typedef enum logic [2:0] {
        DecReset,
        DecLoadUse,
        DecMdStruct,
        DecBranch,
        DecAdvance,
        DecImemWait
    } dec_e;

    localparam logic [7:0] MdCntInit = 8'(MD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  md_cnt_q, md_cnt_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic load_use;
    logic md_struct;
    dec_e dec;

    logic pc_write;
    logic if_id_write;
    logic if_flush;
    logic id_ex_bubble;
    logic md_start;

    // Hazard detection
    always_comb begin
        load_use  = bus.ExMemRead && (bus.ExRt != 5'd0) &&
                    ((bus.ExRt == bus.IdRs) || (bus.IdUsesRt && (bus.ExRt == bus.IdRt)));
        md_struct = (state_q == StMdBusy) && (bus.IdMulDiv || bus.IdUsesMd);
    end

    // Priority decision; a load-use stall hides the branch since its operands are stale
    always_comb begin
        dec = DecAdvance;
        if (!rst) begin
            dec = DecReset;
        end else if (load_use) begin
            dec = DecLoadUse;
        end else if (md_struct) begin
            dec = DecMdStruct;
        end else if (bus.BranchTaken) begin
            dec = DecBranch;
        end else if (!bus.ImemReady) begin
            dec = DecImemWait;
        end
    end

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_flush     = 1'b0;
        id_ex_bubble = 1'b1;
        md_start     = 1'b0;
        unique case (dec)
            DecReset, DecLoadUse, DecMdStruct: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                if_flush     = 1'b0;
                id_ex_bubble = 1'b1;
            end
            DecBranch: begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_flush     = 1'b1;
                id_ex_bubble = 1'b0;
            end
            DecAdvance: begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_flush     = 1'b0;
                id_ex_bubble = 1'b0;
                md_start     = bus.IdMulDiv;
            end
            DecImemWait: begin
                // ID still advances; a nop takes the slot of the missing fetch
                pc_write     = 1'b0;
                if_id_write  = 1'b1;
                if_flush     = 1'b1;
                id_ex_bubble = 1'b0;
                md_start     = bus.IdMulDiv;
            end
            default: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                if_flush     = 1'b0;
                id_ex_bubble = 1'b1;
                md_start     = 1'b0;
            end
        endcase
    end

    // Mul/div occupancy sequencing
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            StRun: begin
                if (md_start) begin
                    state_d  = StMdBusy;
                    md_cnt_d = MdCntInit;
                end
            end
            StMdBusy: begin
                if (md_cnt_q == 8'd0) begin
                    state_d = StRun;
                end else begin
                    md_cnt_d = md_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d  = StRun;
                md_cnt_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_write) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StRun;
            md_cnt_q      <= 8'd0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        bus.PcWrite    = pc_write;
        bus.IfIdWrite  = if_id_write;
        bus.IfFlush    = if_flush;
        bus.IdExBubble = id_ex_bubble;
        bus.MdStart    = md_start;
        bus.MdBusy     = rst && (state_q == StMdBusy);
        bus.StallCount = stall_count_q;
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with MD_CYCLES=4; control outputs are checked
// as one packed vector {PcWrite, IfIdWrite, IfFlush, IdExBubble, MdStart, MdBusy}.
module tb_pipe_stall_ctrl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   exp_sc;
    logic [5:0] ctrl;

    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl #(
        .MD_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign ctrl = {bus.PcWrite, bus.IfIdWrite, bus.IfFlush, bus.IdExBubble,
                   bus.MdStart, bus.MdBusy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.ExMemRead   = 1'b0;
        bus.ExRt        = 5'd0;
        bus.IdRs        = 5'd0;
        bus.IdRt        = 5'd0;
        bus.IdUsesRt    = 1'b0;
        bus.BranchTaken = 1'b0;
        bus.IdMulDiv    = 1'b0;
        bus.IdUsesMd    = 1'b0;
        bus.ImemReady   = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.ExMemRead   = 1'($urandom);
            bus.ExRt        = 5'($urandom);
            bus.IdRs        = 5'($urandom);
            bus.IdRt        = 5'($urandom);
            bus.IdUsesRt    = 1'($urandom);
            bus.BranchTaken = 1'($urandom);
            bus.IdMulDiv    = 1'($urandom);
            bus.IdUsesMd    = 1'($urandom);
            bus.ImemReady   = 1'($urandom);
            #2;
            n_vec++;
            if (ctrl !== 6'b000100) begin
                n_err++;
                $display("FAIL reset_ctrl[%0d]: got %b want %b", i, ctrl, 6'b000100);
            end
            n_vec++;
            if (bus.StallCount !== 32'd0) begin
                n_err++;
                $display("FAIL reset_count[%0d]: got %0d want 0", i, bus.StallCount);
            end
            tick();
        end
        rst = 1'b1;
        set_idle();
        exp_sc = 0;
        #2;
        n_vec++;
        if (ctrl !== 6'b110000) begin
            n_err++;
            $display("FAIL reset_release: got %b want %b", ctrl, 6'b110000);
        end
        tick();
        n_vec++;
        if (bus.StallCount !== 32'(exp_sc)) begin
            n_err++;
            $display("FAIL reset_release_count: got %0d want %0d", bus.StallCount, exp_sc);
        end
    endtask

    task automatic test_load_use();
        set_idle();
        bus.ExMemRead = 1'b1;
        bus.ExRt      = 5'd5;
        bus.IdRs      = 5'd5;
        #2;
        n_vec++;
        if (ctrl !== 6'b000100) begin
            n_err++;
            $display("FAIL load_use_rs: got %b want %b", ctrl, 6'b000100);
        end
        tick();
        exp_sc++;
        set_idle();
        #2;
        n_vec++;
        if (ctrl !== 6'b110000) begin
            n_err++;
            $display("FAIL load_use_drop: got %b want %b", ctrl, 6'b110000);
        end
        n_vec++;
        if (bus.StallCount !== 32'(exp_sc)) begin
            n_err++;
            $display("FAIL load_use_count: got %0d want %0d", bus.StallCount, exp_sc);
        end
        tick();
        // $zero destination never creates a hazard
        bus.ExMemRead = 1'b1;
        bus.ExRt      = 5'd0;
        bus.IdRs      = 5'd0;
        bus.IdRt      = 5'd0;
        bus.IdUsesRt  = 1'b1;
        #2;
        n_vec++;
        if (ctrl !== 6'b110000) begin
            n_err++;
            $display("FAIL load_use_r0: got %b want %b", ctrl, 6'b110000);
        end
        tick();
        bus.ExRt     = 5'd7;
        bus.IdRs     = 5'd3;
        bus.IdRt     = 5'd7;
        bus.IdUsesRt = 1'b1;
        #2;
        n_vec++;
        if (ctrl !== 6'b000100) begin
            n_err++;
            $display("FAIL load_use_rt: got %b want %b", ctrl, 6'b000100);
        end
        tick();
        exp_sc++;
        bus.IdUsesRt = 1'b0;
        #2;
        n_vec++;
        if (ctrl !== 6'b110000) begin
            n_err++;
            $display("FAIL load_use_rt_unused: got %b want %b", ctrl, 6'b110000);
        end
        tick();
        set_idle();
    endtask

    task automatic test_md_occupancy();
        set_idle();
        bus.IdMulDiv = 1'b1;
        #2;
        n_vec++;
        if (ctrl !== 6'b110010) begin
            n_err++;
            $display("FAIL md_start: got %b want %b", ctrl, 6'b110010);
        end
        tick();
        bus.IdMulDiv = 1'b0;
        bus.IdUsesMd = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #2;
            n_vec++;
            if (ctrl !== 6'b000101) begin
                n_err++;
                $display("FAIL mfhi_stall_t%0d: got %b want %b", c, ctrl, 6'b000101);
            end
            tick();
            exp_sc++;
        end
        #2;
        n_vec++;
        if (ctrl !== 6'b110000) begin
            n_err++;
            $display("FAIL mfhi_advance: got %b want %b", ctrl, 6'b110000);
        end
        n_vec++;
        if (bus.StallCount !== 32'(exp_sc)) begin
            n_err++;
            $display("FAIL mfhi_count: got %0d want %0d", bus.StallCount, exp_sc);
        end
        tick();
        set_idle();
    endtask

    task automatic test_md_independent();
        set_idle();
        bus.IdMulDiv = 1'b1;
        tick();
        bus.IdMulDiv = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #2;
            n_vec++;
            if (ctrl !== 6'b110001) begin
                n_err++;
                $display("FAIL md_alu_flow_t%0d: got %b want %b", c, ctrl, 6'b110001);
            end
            tick();
        end
        #2;
        n_vec++;
        if (ctrl !== 6'b110000) begin
            n_err++;
            $display("FAIL md_alu_done: got %b want %b", ctrl, 6'b110000);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        set_idle();
        bus.IdMulDiv = 1'b1;
        tick();
        for (int c = 1; c <= 4; c++) begin
            #2;
            n_vec++;
            if (ctrl !== 6'b000101) begin
                n_err++;
                $display("FAIL b2b_stall_t%0d: got %b want %b", c, ctrl, 6'b000101);
            end
            tick();
            exp_sc++;
        end
        #2;
        n_vec++;
        if (ctrl !== 6'b110010) begin
            n_err++;
            $display("FAIL b2b_issue: got %b want %b", ctrl, 6'b110010);
        end
        tick();
        bus.IdMulDiv = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #2;
            n_vec++;
            if (bus.MdBusy !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_busy_t%0d: got %b want 1", c, bus.MdBusy);
            end
            tick();
        end
        n_vec++;
        if (bus.MdBusy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_release: got %b want 0", bus.MdBusy);
        end
    endtask

    task automatic test_branch();
        set_idle();
        bus.BranchTaken = 1'b1;
        bus.ExMemRead   = 1'b1;
        bus.ExRt        = 5'd9;
        bus.IdRs        = 5'd9;
        #2;
        n_vec++;
        if (ctrl !== 6'b000100) begin
            n_err++;
            $display("FAIL branch_vs_load_use: got %b want %b", ctrl, 6'b000100);
        end
        tick();
        exp_sc++;
        bus.ExMemRead = 1'b0;
        #2;
        n_vec++;
        if (ctrl !== 6'b111000) begin
            n_err++;
            $display("FAIL branch_alone: got %b want %b", ctrl, 6'b111000);
        end
        tick();
        // Illegal mult-with-branch: the branch wins and no mul/div starts
        bus.IdMulDiv = 1'b1;
        #2;
        n_vec++;
        if (ctrl !== 6'b111000) begin
            n_err++;
            $display("FAIL branch_vs_md: got %b want %b", ctrl, 6'b111000);
        end
        tick();
        set_idle();
        #2;
        n_vec++;
        if (ctrl !== 6'b110000) begin
            n_err++;
            $display("FAIL branch_no_md: got %b want %b", ctrl, 6'b110000);
        end
        tick();
    endtask

    task automatic test_imem_wait();
        set_idle();
        bus.ImemReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_vec++;
            if (ctrl !== 6'b011000) begin
                n_err++;
                $display("FAIL imem_wait_%0d: got %b want %b", c, ctrl, 6'b011000);
            end
            tick();
            exp_sc++;
        end
        n_vec++;
        if (bus.StallCount !== 32'(exp_sc)) begin
            n_err++;
            $display("FAIL imem_count: got %0d want %0d", bus.StallCount, exp_sc);
        end
        bus.BranchTaken = 1'b1;
        #2;
        n_vec++;
        if (ctrl !== 6'b111000) begin
            n_err++;
            $display("FAIL imem_branch: got %b want %b", ctrl, 6'b111000);
        end
        tick();
        n_vec++;
        if (bus.StallCount !== 32'(exp_sc)) begin
            n_err++;
            $display("FAIL imem_branch_count: got %0d want %0d", bus.StallCount, exp_sc);
        end
        set_idle();
    endtask

    task automatic test_reset_mid_md();
        set_idle();
        bus.IdMulDiv = 1'b1;
        tick();
        bus.IdMulDiv = 1'b0;
        tick();
        // Counter now at 2 with MdBusy high
        #2;
        n_vec++;
        if (bus.MdBusy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_md_pre: got %b want 1", bus.MdBusy);
        end
        rst = 1'b0;
        #1;
        exp_sc = 0;
        n_vec++;
        if (ctrl !== 6'b000100) begin
            n_err++;
            $display("FAIL rst_md_async: got %b want %b", ctrl, 6'b000100);
        end
        n_vec++;
        if (bus.StallCount !== 32'd0) begin
            n_err++;
            $display("FAIL rst_md_count: got %0d want 0", bus.StallCount);
        end
        #1;
        rst = 1'b1;
        bus.IdMulDiv = 1'b1;
        #2;
        n_vec++;
        if (ctrl !== 6'b110010) begin
            n_err++;
            $display("FAIL rst_md_reissue: got %b want %b", ctrl, 6'b110010);
        end
        tick();
        bus.IdMulDiv = 1'b0;
        #2;
        n_vec++;
        if (ctrl !== 6'b110001) begin
            n_err++;
            $display("FAIL rst_md_busy: got %b want %b", ctrl, 6'b110001);
        end
        n_vec++;
        if (bus.StallCount !== 32'(exp_sc)) begin
            n_err++;
            $display("FAIL rst_md_count_after: got %0d want %0d", bus.StallCount, exp_sc);
        end
        for (int c = 0; c < 4; c++) tick();
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        exp_sc = 0;
        set_idle();
        test_reset();
        test_load_use();
        test_md_occupancy();
        test_md_independent();
        test_back_to_back();
        test_branch();
        test_imem_wait();
        test_reset_mid_md();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Hazard and stall sequencer for the 5-stage MIPS pipeline front end. It drives PC write-enable, IF/ID write-enable, IF/ID flush and the ID/EX bubble. Its inputs are load-use detection, branch redirects in ID, instruction-memory wait and a multi-cycle multiply/divide unit. It sits beside the IF/ID register and owns the only stall/flush decision point in the core.

## Interface

Parameters:
- MD_CYCLES, 32: cycles the mul/div unit stays busy after MdStart (legal 1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ExMemRead  in  1  instruction in EX is a load.
- ExRt  in  5  destination register of the EX load.
- IdRs  in  5  rs field of the ID instruction.
- IdRt  in  5  rt field of the ID instruction.
- IdUsesRt  in  1  ID instruction reads rt.
- BranchTaken  in  1  branch/jump in ID resolved taken (redirect).
- IdMulDiv  in  1  ID instruction is a mult/div.
- IdUsesMd  in  1  ID instruction reads HI/LO (mfhi/mflo).
- ImemReady  in  1  instruction memory delivers a valid fetch this cycle.
- PcWrite  out  1  PC register load enable.
- IfIdWrite  out  1  IF/ID register write enable.
- IfFlush  out  1  IF/ID register flush (loads a nop).
- IdExBubble  out  1  zero the control fields entering ID/EX.
- MdStart  out  1  one-cycle start pulse to the mul/div unit.
- MdBusy  out  1  mul/div unit occupied (state MD_BUSY).
- StallCount  out  32  count of cycles with PcWrite=0 since reset.

## Operation

- State: RUN, MD_BUSY. Counter: mdCnt, 8 bits. Perf counter: StallCount.
- Control outputs are combinational from the state and inputs. The decision is made in priority order; the first matching rule applies.
- **1. Load-use.** Condition: ExMemRead && ExRt!=0 && (ExRt==IdRs || (IdUsesRt && ExRt==IdRt)).
  - Outputs: PcWrite=0, IfIdWrite=0, IfFlush=0, IdExBubble=1, MdStart=0.
  - BranchTaken is ignored because its operands are not ready.
- **2. Mul/div structural.** Condition: state MD_BUSY && (IdMulDiv || IdUsesMd).
  - Outputs: same as load-use stall.
- **3. Branch.** Condition: BranchTaken.
  - Outputs: PcWrite=1, IfIdWrite=1, IfFlush=1, IdExBubble=0, MdStart=0.
  - Applies even when ImemReady=0; the fetch restarts at the target.
- **4. Default advance.** IfIdWrite=1, IdExBubble=0.
  - MdStart=IdMulDiv (reachable only when state RUN, because rule 2 catches MD_BUSY).
  - If ImemReady: PcWrite=1, IfFlush=0.
  - Else: PcWrite=0, IfFlush=1, inserting a nop into ID while the ID instruction still advances.
- IdMulDiv && BranchTaken together is illegal; if it occurs, branch wins and MdStart=0.
- **Transitions:**
  - RUN -> MD_BUSY when MdStart=1; mdCnt <= MD_CYCLES-1.
  - MD_BUSY: if mdCnt==0 -> RUN, else mdCnt <= mdCnt-1.
  - MdBusy=1 for exactly MD_CYCLES cycles following the MdStart cycle.
- Independent instructions (not mul/div, not HI/LO readers) flow normally during MD_BUSY, subject to rules 1, 3 and 4.
- StallCount increments on every cycle with PcWrite=0 while out of reset. It wraps mod 2^32.

## Timing

- **Reset (rst=0, asynchronous):** state RUN, mdCnt=0, StallCount=0.
  - While rst=0, outputs are forced to PcWrite=0, IfIdWrite=0, IfFlush=0, IdExBubble=1, MdStart=0, MdBusy=0.
  - StallCount does not count during reset.
- **Reset asserted mid-MD_BUSY:** abandons the count immediately. After release the block is in RUN with MdBusy=0.
- **Load-use stall:** lasts exactly one cycle per hazard. The next cycle the load sits in MEM and the condition drops, assuming ExMemRead is deasserted by the inserted bubble.
- **Flush:** takes effect at the same rising edge as the PC redirect. Zero added latency beyond the one killed fetch.
- **MdStart:** asserted in the same cycle the mul/div occupies ID. MdBusy rises on the following edge.
- **mfhi behind a mult:**
  - mult issued at cycle t with MD_CYCLES=N.
  - An mfhi in ID stalls cycles t+1..t+N.
  - It advances at cycle t+N+1.
- **Back-to-back mult:** the second one stalls until state returns to RUN, then issues its own MdStart.
- **ImemReady low for k cycles:** PcWrite=0 and IfFlush=1 for those k cycles; StallCount increases by k.

## Test plan

- **Reset:** rst low with random inputs -> IdExBubble=1, all other control outputs 0, MdBusy=0, StallCount=0. Release -> with ImemReady=1 and no hazards: PcWrite=1, IfIdWrite=1, IfFlush=0, IdExBubble=0.
- **Load-use:** ExMemRead=1, ExRt=5, IdRs=5 -> one cycle of PcWrite=0, IfIdWrite=0, IdExBubble=1; StallCount=1. Repeat with ExRt=0 -> no stall.
- **Mul/div occupancy:** MD_CYCLES=4, IdMulDiv=1 at t -> MdStart=1 at t; MdBusy=1 for t+1..t+4. IdUsesMd=1 from t+1 -> stalled t+1..t+4, IfIdWrite=1 at t+5. Independent ALU op at t+1 -> no stall.
- **Branch vs load-use:** BranchTaken=1 with a concurrent load-use hazard -> IfFlush=0, stall. Next cycle, BranchTaken=1 alone -> IfFlush=1, PcWrite=1.
- **Imem wait:** ImemReady=0 for 3 cycles -> PcWrite=0, IfFlush=1 each cycle; StallCount+=3. BranchTaken during the wait -> PcWrite=1, IfFlush=1.
- **Reset mid-MD_BUSY:** at mdCnt=2, pulse rst low -> MdBusy=0 immediately. After release a new IdMulDiv issues MdStart with no stall.
